// File: rtl/softmax_normalizer.sv
// Softmax normalizer: buffers a clamped exponent vector, forms 2^42/sum with a
// restoring divider, then streams saturated Q0.16 probabilities under backpressure.
module softmax_normalizer #(
  parameter int N             = 32,
  parameter int IN_BIT_WIDTH  = 16,
  parameter int SUM_BIT_WIDTH = 32,
  parameter int OUT_BIT_WIDTH = 16,
  parameter int RECIP_WIDTH   = 32
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_valid,
  input  logic [N-1:0][IN_BIT_WIDTH-1:0]      i_data,
  output logic                                o_in_ready,
  input  logic                                i_sum_valid,
  input  logic [SUM_BIT_WIDTH-1:0]            i_sum,
  output logic                                o_valid,
  input  logic                                i_ready,
  output logic [OUT_BIT_WIDTH-1:0]            o_prob,
  output logic [$clog2(N)-1:0]                o_idx,
  output logic                                o_last,
  output logic                                o_dz
);

  localparam int IDX_W      = $clog2(N);
  localparam int MAG_W      = IN_BIT_WIDTH - 1;
  localparam int QUO_W      = 43;
  localparam int CNT_W      = 6;
  localparam int FRAC_SHIFT = 12;
  localparam int PROD_W     = MAG_W + RECIP_WIDTH;
  localparam int SCALED_W   = PROD_W - FRAC_SHIFT;

  typedef enum logic [1:0] {IDLE, WAIT_SUM, DIV, EMIT} state_t;

  state_t state, state_nxt;

  logic [MAG_W-1:0]         x_buf [N];
  logic [SUM_BIT_WIDTH-1:0] den;
  logic [SUM_BIT_WIDTH-1:0] rem;
  logic [QUO_W-1:0]         quo;
  logic [CNT_W-1:0]         cnt;
  logic [IDX_W-1:0]         idx;
  logic                     dz;

  logic [SUM_BIT_WIDTH:0]   rem_sh;
  logic [SUM_BIT_WIDTH-1:0] rem_sub;
  logic                     q_bit;
  logic                     div_done;
  logic                     idx_last;
  logic                     hs;
  logic [RECIP_WIDTH-1:0]   recip;

  function automatic logic [MAG_W-1:0] clamp_mag(input logic signed [IN_BIT_WIDTH-1:0] v);
    return v[IN_BIT_WIDTH-1] ? '0 : v[MAG_W-1:0];
  endfunction

  function automatic logic [RECIP_WIDTH-1:0] sat_recip(input logic [QUO_W-1:0] q);
    return (|q[QUO_W-1:RECIP_WIDTH]) ? '1 : q[RECIP_WIDTH-1:0];
  endfunction

  function automatic logic [OUT_BIT_WIDTH-1:0] sat_prob(input logic [MAG_W-1:0] x,
                                                       input logic [RECIP_WIDTH-1:0] r);
    logic [SCALED_W-1:0] scaled;
    scaled = SCALED_W'((PROD_W'(x) * PROD_W'(r)) >> FRAC_SHIFT);
    return (|scaled[SCALED_W-1:OUT_BIT_WIDTH]) ? '1 : scaled[OUT_BIT_WIDTH-1:0];
  endfunction

  // Dividend is 2^42, so only the first shifted-in bit is a one.
  always_comb begin
    rem_sh   = {rem, (cnt == '0)};
    q_bit    = rem_sh[SUM_BIT_WIDTH] | (rem_sh[SUM_BIT_WIDTH-1:0] >= den);
    rem_sub  = rem_sh[SUM_BIT_WIDTH-1:0] - den;
    div_done = (cnt == CNT_W'(QUO_W - 1));
    idx_last = (idx == IDX_W'(N - 1));
    hs       = (state == EMIT) && i_ready;
    recip    = sat_recip(quo);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (i_valid) state_nxt = WAIT_SUM;
      WAIT_SUM: if (i_sum_valid) state_nxt = (i_sum == '0) ? EMIT : DIV;
      DIV:      if (div_done) state_nxt = EMIT;
      EMIT:     if (hs && idx_last) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dz  <= 1'b0;
      idx <= '0;
      cnt <= '0;
    end else begin
      case (state)
        WAIT_SUM: if (i_sum_valid) begin
          dz  <= (i_sum == '0);
          idx <= '0;
          cnt <= '0;
        end
        DIV:  cnt <= cnt + 1'b1;
        EMIT: if (hs) begin
          idx <= idx + 1'b1;
          if (idx_last) dz <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (state == IDLE && i_valid) begin
      for (int k = 0; k < N; k++) x_buf[k] <= clamp_mag(i_data[k]);
    end
    if (state == WAIT_SUM && i_sum_valid) begin
      den <= i_sum;
      rem <= '0;
    end
    if (state == DIV) begin
      rem <= q_bit ? rem_sub : rem_sh[SUM_BIT_WIDTH-1:0];
      quo <= {quo[QUO_W-2:0], q_bit};
    end
  end

  assign o_in_ready = (state == IDLE);
  assign o_valid    = (state == EMIT);
  assign o_idx      = o_valid ? idx : '0;
  assign o_last     = o_valid && idx_last;
  assign o_dz       = o_valid && dz;
  assign o_prob     = (o_valid && !dz) ? sat_prob(x_buf[idx], recip) : '0;

endmodule

// File: tb/tb_softmax_normalizer.sv
// Directed bench for softmax_normalizer with hand-computed expected probabilities.
module tb_softmax_normalizer;
  localparam int N = 32;

  logic                 clk = 1'b0;
  logic                 i_rst;
  logic                 i_valid;
  logic [N-1:0][15:0]   i_data;
  logic                 o_in_ready;
  logic                 i_sum_valid;
  logic [31:0]          i_sum;
  logic                 o_valid;
  logic                 i_ready;
  logic [15:0]          o_prob;
  logic [4:0]           o_idx;
  logic                 o_last;
  logic                 o_dz;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  softmax_normalizer dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
    .o_in_ready(o_in_ready), .i_sum_valid(i_sum_valid), .i_sum(i_sum),
    .o_valid(o_valid), .i_ready(i_ready), .o_prob(o_prob), .o_idx(o_idx),
    .o_last(o_last), .o_dz(o_dz)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_vec(input logic [N-1:0][15:0] v, input logic sum_too);
    i_data = v; i_valid = 1'b1; i_sum_valid = sum_too; i_sum = '0;
    @(posedge clk); #1;
    i_valid = 1'b0; i_sum_valid = 1'b0;
    check("capture_in_ready", o_in_ready, 1'b0);
    check("capture_valid", o_valid, 1'b0);
  endtask

  task automatic send_sum(input logic [31:0] s);
    i_sum = s; i_sum_valid = 1'b1;
    @(posedge clk); #1;
    i_sum_valid = 1'b0;
  endtask

  task automatic wait_emit(input int exp_lat, input bit pulse);
    int e;
    e = 1;
    while (o_valid !== 1'b1 && e < 100) begin
      if (pulse) begin
        i_valid = (e % 3 == 1);
        check("div_in_ready", o_in_ready, 1'b0);
      end
      @(posedge clk); #1;
      e++;
    end
    i_valid = 1'b0;
    check("latency", e, exp_lat);
  endtask

  task automatic receive(input logic [15:0] first, input logic [15:0] even,
                         input logic [15:0] odd, input logic dz, input bit bp, input bit pulse);
    int k, c;
    logic rdy;
    logic [15:0] exp;
    k = 0; c = 0;
    while (k < N && c < 400) begin
      rdy = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      i_ready = rdy;
      i_valid = pulse && (c % 5 == 2);
      exp = (k == 0) ? first : ((k % 2 == 0) ? even : odd);
      check("emit_valid", o_valid, 1'b1);
      check("emit_in_ready", o_in_ready, 1'b0);
      check($sformatf("prob[%0d]", k), o_prob, exp);
      check($sformatf("idx[%0d]", k), o_idx, k[4:0]);
      check($sformatf("last[%0d]", k), o_last, (k == N - 1));
      check($sformatf("dz[%0d]", k), o_dz, dz);
      @(posedge clk); #1;
      if (rdy) k++;
      c++;
    end
    i_ready = 1'b0; i_valid = 1'b0;
    check("beat_count", k, N);
    check("done_valid", o_valid, 1'b0);
    check("done_in_ready", o_in_ready, 1'b1);
    check("done_last", o_last, 1'b0);
    check("done_dz", o_dz, 1'b0);
    check("done_prob", o_prob, 16'h0000);
  endtask

  initial begin
    logic [N-1:0][15:0] uni, onehot, clampv, zerov, tiny, junk;
    for (int k = 0; k < N; k++) begin
      uni[k]    = 16'h1000;
      onehot[k] = (k == 0) ? 16'h1000 : 16'h0000;
      clampv[k] = (k % 2 == 0) ? 16'h1000 : 16'hF800;
      zerov[k]  = 16'h0000;
      tiny[k]   = (k == 0) ? 16'h0001 : 16'h0000;
      junk[k]   = 16'h7FFF;
    end
    i_rst = 1'b1; i_valid = 1'b0; i_data = '0; i_sum_valid = 1'b0; i_sum = '0; i_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", o_valid, 1'b0);
    check("rst_in_ready", o_in_ready, 1'b1);
    check("rst_last", o_last, 1'b0);
    check("rst_dz", o_dz, 1'b0);
    check("rst_idx", o_idx, 5'd0);
    check("rst_prob", o_prob, 16'h0000);
    i_rst = 1'b0;

    // Uniform: R = 2^42/2^31 = 2048, 4096*2048>>12 = 0x0800; zero sum in IDLE ignored.
    send_vec(uni, 1'b1);
    send_sum(32'h8000_0000);
    wait_emit(44, 1'b0);
    receive(16'h0800, 16'h0800, 16'h0800, 1'b0, 1'b0, 1'b0);

    // One-hot: R = 65536, 4096*65536>>12 = 2^16 -> saturated.
    send_vec(onehot, 1'b0);
    send_sum(32'h0400_0000);
    wait_emit(44, 1'b0);
    receive(16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Clamp: R = 4096, positive 0x1000 -> 0x1000, negatives -> 0.
    send_vec(clampv, 1'b0);
    send_sum(32'h4000_0000);
    wait_emit(44, 1'b0);
    receive(16'h1000, 16'h1000, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Zero denominator.
    send_vec(zerov, 1'b0);
    send_sum(32'h0000_0000);
    wait_emit(1, 1'b0);
    receive(16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Backpressure plus ignored i_valid pulses carrying junk data.
    send_vec(uni, 1'b0);
    i_data = junk;
    repeat (2) begin
      i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      check("wait_in_ready", o_in_ready, 1'b0);
    end
    send_sum(32'h8000_0000);
    wait_emit(44, 1'b1);
    receive(16'h0800, 16'h0800, 16'h0800, 1'b0, 1'b1, 1'b1);
    i_data = '0;

    // Reciprocal saturation: 2^42/2^10 = 2^32 overflows to 0xFFFF_FFFF.
    send_vec(tiny, 1'b0);
    send_sum(32'h0000_0400);
    wait_emit(44, 1'b0);
    receive(16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Reset during the divider, then a fresh uniform vector.
    send_vec(onehot, 1'b0);
    send_sum(32'h0400_0000);
    repeat (19) @(posedge clk);
    #1;
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    check("mid_rst_valid", o_valid, 1'b0);
    check("mid_rst_in_ready", o_in_ready, 1'b1);
    check("mid_rst_idx", o_idx, 5'd0);
    check("mid_rst_prob", o_prob, 16'h0000);
    send_vec(uni, 1'b0);
    send_sum(32'h8000_0000);
    wait_emit(44, 1'b0);
    receive(16'h0800, 16'h0800, 16'h0800, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
